serial_addsub_mag: RTL and testbench

//  Parametrised, digit-serial adder/subtractor with sign-magnitude output.
//  Add: f = (a+b) mod 2^WIDTH, cy = carry-out. Sub: f = |a-b|, cy = 1 iff a<b.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_digit.sv | 15 +
 rtl/serial_addsub_mag.sv | 130 +++++++++++++
 tb/tb_serial_addsub_mag.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract-with-magnitude datapath.
// FSM state encodings and the digit-counter width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple adder; one instance serves both the add
// pass and the two's-complement correction pass.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_addsub_mag.sv
// Digit-serial adder/subtractor with sign-magnitude result and valid/ready
// handshakes; a second serial pass negates the result when a < b.
module serial_addsub_mag #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cy
);
    import addsub_pkg::*;

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = clog2(N);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_addsub_mag: WIDTH must be a multiple of DIGIT");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, f_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, sub_q, cy_q;
    logic               in_ready_q, out_valid_q;

    logic [DIGIT-1:0]   op_x, op_y, sum_dig;
    logic               carry_out;
    logic [WIDTH-1:0]   f_d;
    logic               last_digit;

    // FIX pass computes ~f + 1: inverted f digit plus zero, carry seeded to 1.
    assign op_x       = (state_q == ST_FIX) ? ~f_q[DIGIT-1:0] : a_q[DIGIT-1:0];
    assign op_y       = (state_q == ST_FIX) ? '0 : b_q[DIGIT-1:0];
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (op_x),
        .y    (op_y),
        .cin  (carry_q),
        .s    (sum_dig),
        .cout (carry_out)
    );

    if (DIGIT == WIDTH) begin : g_single_digit
        assign f_d = sum_dig;
    end else begin : g_multi_digit
        assign f_d = {sum_dig, f_q[WIDTH-1:DIGIT]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        sub_q      <= sub;
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    f_q     <= f_d;
                    carry_q <= carry_out;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        cnt_q <= '0;
                        cy_q  <= sub_q ? ~carry_out : carry_out;
                        if (sub_q && !carry_out) begin
                            carry_q <= 1'b1;
                            state_q <= ST_FIX;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_FIX: begin
                    f_q     <= f_d;
                    carry_q <= carry_out;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign cy        = cy_q;

endmodule

// File: tb/tb_serial_addsub_mag.sv
// Bench for serial_addsub_mag: directed vectors on an N=4 instance and a
// random back-to-back stream on an N=1 instance, both against a model.
module tb_serial_addsub_mag;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N = 4 instance
    logic       in_valid_n4 = 1'b0, sub_n4 = 1'b0, out_ready_n4 = 1'b1;
    logic [7:0] a_n4 = '0, b_n4 = '0;
    logic       in_ready_n4, out_valid_n4, cy_n4;
    logic [7:0] f_n4;

    // N = 1 instance
    logic       in_valid_n1 = 1'b0, sub_n1 = 1'b0, out_ready_n1 = 1'b1;
    logic [7:0] a_n1 = '0, b_n1 = '0;
    logic       in_ready_n1, out_valid_n1, cy_n1;
    logic [7:0] f_n1;

    logic [8:0] q4[$];
    logic [8:0] q1[$];
    logic       rand_phase = 1'b0;

    serial_addsub_mag #(.WIDTH(8), .DIGIT(2)) u_dut_n4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_n4), .in_ready(in_ready_n4),
        .a(a_n4), .b(b_n4), .sub(sub_n4), .out_valid(out_valid_n4),
        .out_ready(out_ready_n4), .f(f_n4), .cy(cy_n4)
    );

    serial_addsub_mag #(.WIDTH(8), .DIGIT(8)) u_dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_n1), .in_ready(in_ready_n1),
        .a(a_n1), .b(b_n1), .sub(sub_n1), .out_valid(out_valid_n1),
        .out_ready(out_ready_n1), .f(f_n1), .cy(cy_n1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {cy, f}: sum with carry-out, or sign and magnitude of a-b.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        if (!s)         return {1'b0, x} + {1'b0, y};
        else if (x >= y) return {1'b0, x - y};
        else            return {1'b1, y - x};
    endfunction

    // Compare process: checks every cycle an output is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (rand_phase) out_ready_n1 = ($urandom_range(0, 3) != 0);
            if (out_valid_n4) begin
                if (q4.size() == 0) check("n4_unexpected_out_valid", 1, 0);
                else begin
                    check("n4_f", f_n4, q4[0][7:0]);
                    check("n4_cy", cy_n4, q4[0][8]);
                    check("n4_in_ready_in_done", in_ready_n4, 0);
                    if (out_ready_n4) void'(q4.pop_front());
                end
            end
            if (out_valid_n1) begin
                if (q1.size() == 0) check("n1_unexpected_out_valid", 1, 0);
                else begin
                    check("n1_f", f_n1, q1[0][7:0]);
                    check("n1_cy", cy_n1, q1[0][8]);
                    if (out_ready_n1) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic s);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready_n4 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("n4_in_ready_timeout", 0, 1);
        a_n4 = x; b_n4 = y; sub_n4 = s; in_valid_n4 = 1'b1;
        q4.push_back(model(x, y, s));
        @(posedge clk);
        #1;
        in_valid_n4 = 1'b0;
        a_n4 = ~x; b_n4 = ~y; sub_n4 = ~s;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          input logic [7:0] ef, input logic ecy, input int elat);
        int lat;
        logic [8:0] m;
        m = model(x, y, s);
        check("model_f", m[7:0], ef);
        check("model_cy", m[8], ecy);
        start_op(x, y, s);
        lat = 0;
        while (!out_valid_n4 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, elat);
        check("result_f", f_n4, ef);
        check("result_cy", cy_n4, ecy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] x, y;
        logic s;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_n4, 1);
        check("rst_out_valid", out_valid_n4, 0);
        check("rst_f", f_n4, 0);
        check("rst_cy", cy_n4, 0);
        check("rst_n1_in_ready", in_ready_n1, 1);
        check("rst_n1_out_valid", out_valid_n1, 0);
        rst = 1'b0;

        run_op(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 4);
        run_op(8'd10,  8'd5,   1'b1, 8'd5,   1'b0, 4);
        run_op(8'd7,   8'd7,   1'b1, 8'd0,   1'b0, 4);
        run_op(8'd5,   8'd10,  1'b1, 8'd5,   1'b1, 8);
        run_op(8'd0,   8'd255, 1'b1, 8'd255, 1'b1, 8);
        run_op(8'd0,   8'd0,   1'b1, 8'd0,   1'b0, 4);
        run_op(8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 4);
        run_op(8'd3,   8'd4,   1'b0, 8'd7,   1'b0, 4);

        // Backpressure: result held while out_ready is low, new requests ignored.
        @(posedge clk);
        #1;
        out_ready_n4 = 1'b0;
        run_op(8'd10, 8'd5, 1'b1, 8'd5, 1'b0, 4);
        in_valid_n4 = 1'b1; a_n4 = 8'd1; b_n4 = 8'd1; sub_n4 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid_n4, 1);
            check("bp_f", f_n4, 5);
            check("bp_cy", cy_n4, 0);
            check("bp_in_ready", in_ready_n4, 0);
        end
        in_valid_n4 = 1'b0;
        out_ready_n4 = 1'b1;
        @(posedge clk);
        #1;
        check("handoff_out_valid", out_valid_n4, 0);
        check("handoff_in_ready", in_ready_n4, 1);
        check("handoff_f_kept", f_n4, 5);
        check("handoff_cy_kept", cy_n4, 0);

        // Abort 5-10 during its correction pass.
        start_op(8'd5, 8'd10, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q4.delete();
        check("abort_out_valid", out_valid_n4, 0);
        check("abort_f", f_n4, 0);
        check("abort_cy", cy_n4, 0);
        check("abort_in_ready", in_ready_n4, 1);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid_n4) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 0);
        run_op(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 4);

        // N = 1: back-to-back random operations.
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            a_n1 = x; b_n1 = y; sub_n1 = s; in_valid_n1 = 1'b1;
            q1.push_back(model(x, y, s));
            k = 0;
            while (!in_ready_n1 && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) check("n1_in_ready_timeout", 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid_n1 = 1'b0;
        k = 0;
        while ((q1.size() != 0 || q4.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("n1_queue_drained", q1.size(), 0);
        check("n4_queue_drained", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
